high_z_nor: RTL and testbench

HIGH_Z_NOR -- requirements
Module: high_z_nor

---
 rtl/high_z_nor.sv | 46 ++++
 tb/tb_high_z_nor.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/high_z_nor.sv
// Tri-state NOR gate with registered NOR/enable taps and a
// saturating counter of output-disabled cycles.
module high_z_nor #(
  parameter int CNT_W = 8
) (
  input  logic             in1,
  input  logic             in2,
  input  logic             in3,
  output logic             out1,
  input  logic             clk,
  input  logic             rst,
  output logic             nor_q,
  output logic             oe_q,
  output logic [CNT_W-1:0] z_cnt
);

  logic             w_nor;
  logic             w_sat;
  logic             r_nor;
  logic             r_oe;
  logic [CNT_W-1:0] r_z_cnt;

  assign w_nor = ~(in1 | in2);
  assign w_sat = &r_z_cnt;

  // An unknown in3 merges z with the NOR value, which yields x.
  assign out1 = in3 ? 1'bz : w_nor;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_nor   <= 1'b0;
      r_oe    <= 1'b0;
      r_z_cnt <= '0;
    end else begin
      r_nor <= w_nor;
      r_oe  <= ~in3;
      if (in3 && !w_sat)
        r_z_cnt <= r_z_cnt + 1'b1;
    end
  end

  assign nor_q = r_nor;
  assign oe_q  = r_oe;
  assign z_cnt = r_z_cnt;

endmodule

// File: tb/tb_high_z_nor.sv
// Bench for high_z_nor: combinational tri-state checks plus a
// cycle model of the registered taps and saturating counter.
module tb_high_z_nor;

  logic       clk;
  logic       rst;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       clk_en;
  tri         out_pu;
  tri         out_pd;
  tri         out_2;
  logic       nor_a, oe_a, nor_b, oe_b, nor_2, oe_2;
  logic [7:0] cnt_a, cnt_b;
  logic [1:0] cnt_2;

  int n_chk;
  int n_err;

  pullup   (out_pu);
  pulldown (out_pd);

  high_z_nor #(.CNT_W(8)) dut (
    .in1(in1), .in2(in2), .in3(in3), .out1(out_pu),
    .clk(clk), .rst(rst),
    .nor_q(nor_a), .oe_q(oe_a), .z_cnt(cnt_a));

  high_z_nor #(.CNT_W(8)) dut_pd (
    .in1(in1), .in2(in2), .in3(in3), .out1(out_pd),
    .clk(clk), .rst(rst),
    .nor_q(nor_b), .oe_q(oe_b), .z_cnt(cnt_b));

  high_z_nor #(.CNT_W(2)) dut2 (
    .in1(in1), .in2(in2), .in3(in3), .out1(out_2),
    .clk(clk), .rst(rst),
    .nor_q(nor_2), .oe_q(oe_2), .z_cnt(cnt_2));

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  // Model: plain count of disabled cycles since reset, clipped on read.
  bit          m_valid;
  logic        m_nor;
  logic        m_oe;
  int unsigned m_z;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_nor   = 1'b0;
      m_oe    = 1'b0;
      m_z     = 0;
    end else if (m_valid) begin
      m_nor = !(in1 || in2);
      m_oe  = !in3;
      if (in3) m_z = m_z + 1;
    end
  end

  function automatic int unsigned sat(int unsigned v, int w);
    int unsigned mx;
    mx = (32'd1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // code: 0/1 driven value, 2 high-Z, 3 unknown
  task automatic chk_out(string name, int code);
    bit ok;
    n_chk++;
    case (code)
      0, 1:    ok = (out_pu === code[0]) && (out_pd === code[0]);
      2:       ok = (out_pu === 1'b1) && (out_pd === 1'b0);
      default: ok = (out_pu === 1'bx) && (out_pd === 1'bx);
    endcase
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got pu=%b pd=%b expected code %0d",
               name, out_pu, out_pd, code);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("nor_q", {31'd0, nor_a}, {31'd0, m_nor});
      chk("oe_q", {31'd0, oe_a}, {31'd0, m_oe});
      chk("z_cnt8", {24'd0, cnt_a}, sat(m_z, 8));
      chk("z_cnt2", {30'd0, cnt_2}, sat(m_z, 2));
      chk_out("out1_cyc", in3 ? 2 : int'(!(in1 || in2)));
    end
  end

  task automatic step(logic r, logic a, logic b, logic c);
    rst = r; in1 = a; in2 = b; in3 = c;
    @(posedge clk);
    #1;
  endtask

  logic four_state;
  logic [1:0] pat;

  initial begin
    n_chk = 0; n_err = 0;
    clk_en = 1'b0; m_valid = 1'b0;
    rst = 1'b0; in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
    four_state = 1'bx;

    // Idle-clock combinational sweeps
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      in1 = pat[0]; in2 = pat[1]; in3 = 1'b0;
      #1 chk_out("sweep_en", (i == 0) ? 1 : 0);
    end
    for (int i = 0; i < 4; i++) begin
      pat = 2'(i);
      in1 = pat[0]; in2 = pat[1]; in3 = 1'b1;
      #1 chk_out("sweep_z", 2);
    end
    in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
    #1 chk_out("back_000", 1);
    in1 = 1'bx; in2 = 1'b1;
    #1 chk_out("x_or_1", 0);
    if (four_state === 1'bx) begin
      in2 = 1'b0;
      #1 chk_out("x_or_0", 3);
      in1 = 1'b0; in3 = 1'bx;
      #1 chk_out("in3_x", 3);
    end
    in1 = 1'b0; in2 = 1'b0; in3 = 1'b0;
    #1;

    clk_en = 1'b1;
    step(1, 0, 0, 0);
    chk("rst_nor", {31'd0, nor_a}, 0);
    chk("rst_oe", {31'd0, oe_a}, 0);
    chk("rst_cnt", {24'd0, cnt_a}, 0);

    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    chk("five_cnt", {24'd0, cnt_a}, 5);
    chk("five_oe", {31'd0, oe_a}, 0);
    chk("five_nor", {31'd0, nor_a}, 1);
    step(0, 0, 0, 1);
    chk("six_cnt2", {30'd0, cnt_2}, 3);
    chk("six_cnt8", {24'd0, cnt_a}, 6);

    // Enabled patterns: counter holds, taps track inputs
    step(0, 1, 0, 0);
    chk("hold_cnt", {24'd0, cnt_a}, 6);
    chk("en_nor", {31'd0, nor_a}, 0);
    chk("en_oe", {31'd0, oe_a}, 1);
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    chk("nor_00", {31'd0, nor_a}, 1);
    step(0, 1, 0, 1);
    chk("nor_while_z", {31'd0, nor_a}, 0);
    chk("cnt_7", {24'd0, cnt_a}, 7);

    // Reset while disabled and z_cnt == 3
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("pre_cnt3", {24'd0, cnt_a}, 3);
    rst = 1'b1;
    #1 chk_out("rst_z_pre", 2);
    step(1, 0, 0, 1);
    chk("r30_cnt", {24'd0, cnt_a}, 0);
    chk("r30_nor", {31'd0, nor_a}, 0);
    chk("r30_oe", {31'd0, oe_a}, 0);
    chk_out("rst_z_post", 2);
    step(0, 0, 0, 1);
    chk("resume_cnt", {24'd0, cnt_a}, 1);
    chk("resume_nor", {31'd0, nor_a}, 1);

    // Long saturation run on the 8-bit counter
    for (int i = 0; i < 260; i++) step(0, 0, 1, 1);
    chk("sat8", {24'd0, cnt_a}, 255);
    chk("sat8_b", {24'd0, cnt_b}, 255);
    step(0, 0, 0, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
